// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard beside ID: shift-register of in-flight destinations, stall
// detection and saturating stall counter. Define FORWARDING_EN for the forwarding stall rules.
module hazard_scoreboard #(
    parameter int RW       = 5,
    parameter int DEPTH    = 4,
    parameter int LOAD_LAT = 1,
    parameter int CNTW     = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [RW-1:0]   id_dest,
    input  logic            id_we,
    input  logic            id_is_load,
    input  logic            id_is_branch,
    input  logic            flush,
    output logic            id_stall,
    output logic [CNTW-1:0] stall_count
);

    logic [DEPTH-1:0]         ent_v;
    logic [DEPTH-1:0][RW-1:0] ent_dest;
    logic [DEPTH-1:0]         ent_ld;

    logic hit;
    logic match_k;
    logic blk;

    // Stall decision: entries (age = index) against the sources ID actually reads
    always_comb begin
        hit     = 1'b0;
        match_k = 1'b0;
        blk     = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            match_k = ent_v[k] &&
                      ((id_uses_rs && (id_rs != '0) && (ent_dest[k] == id_rs)) ||
                       (id_uses_rt && (id_rt != '0) && (ent_dest[k] == id_rt)));
`ifdef FORWARDING_EN
            if (id_is_branch)
                blk = ent_ld[k] ? (k < LOAD_LAT + 1) : (k < 1);
            else
                blk = ent_ld[k] && (k < LOAD_LAT);
`else
            blk = 1'b1;
`endif
            hit = hit | (match_k & blk);
        end
        id_stall = id_valid & hit;
    end

`ifndef FORWARDING_EN
    // Without forwarding the load flag and branch type do not change the outcome.
    logic unused_fields;
    assign unused_fields = ^{id_is_branch, ent_ld};
`endif

    // Control state: valid bits and stall counter (reset beats flush)
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_v       <= '0;
            stall_count <= '0;
        end else begin
            if (flush)
                ent_v <= '0;
            else
                ent_v <= {ent_v[DEPTH-2:0],
                          id_valid & id_we & (id_dest != '0) & ~id_stall};
            if (id_stall && (stall_count != '1))
                stall_count <= stall_count + CNTW'(1);
        end
    end

    // Data fields shift unconditionally; they are only meaningful where ent_v is set
    always_ff @(posedge clk) begin
        ent_dest <= {ent_dest[DEPTH-2:0], id_dest};
        ent_ld   <= {ent_ld[DEPTH-2:0], id_is_load};
    end

endmodule
